// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg
//   Shared constants for the writeback-side register file and its scoreboard.
//   No ports; imported by regfile_wb, regfile_wb_if and regfile_wb_scoreboard.
package regfile_wb_pkg;

    localparam int   REG_BUS_W    = 32;          // register width
    localparam int   REG_ADDR_W   = 5;           // register index width
    localparam int   REG_NUM      = 32;          // number of architectural registers
    localparam int   REG_NUM_LOG2 = 5;

    localparam logic RST_ENABLE    = 1'b1;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic STOP          = 1'b1;

    localparam logic [REG_BUS_W-1:0]  ZERO_WORD    = '0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

endpackage

// File: rtl/regfile_wb_if.sv
// regfile_wb_if
//   Bundles the writeback, ID read, scoreboard mark/flush and stall signals.
//   master : pipeline side (MEM/WB writes, ID reads/marks, flush)
//   slave  : register file side (returns read data and stallreq)
interface regfile_wb_if
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W,
    parameter int ADDR_W = REG_ADDR_W
);
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_wdata;
    logic              wb_wreg;

    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;

    logic              mark_valid;
    logic [ADDR_W-1:0] mark_rd;
    logic              flush;
    logic              stallreq;

    modport master (
        output wb_rd, wb_wdata, wb_wreg,
        output re1, raddr1, re2, raddr2,
        output mark_valid, mark_rd, flush,
        input  rdata1, rdata2, stallreq
    );

    modport slave (
        input  wb_rd, wb_wdata, wb_wreg,
        input  re1, raddr1, re2, raddr2,
        input  mark_valid, mark_rd, flush,
        output rdata1, rdata2, stallreq
    );

endinterface

// File: rtl/regfile_wb_scoreboard.sv
// regfile_wb_scoreboard
//   Per-register pending bits for long-latency (load) producers and the
//   combinational load-use stall request.
//   Ports:
//     clk_i, rst_i                  clock, synchronous active-high reset
//     wb_rd_i, wb_wreg_i            writeback clears pending[wb_rd]
//     mark_valid_i, mark_rd_i       issue sets pending[mark_rd]
//     flush_i                       clears every pending bit, drops a same-cycle mark
//     re1_i/raddr1_i, re2_i/raddr2_i  ID read ports being checked
//     stallreq_o                    ID must hold the consumer
module regfile_wb_scoreboard
    import regfile_wb_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int NUM    = REG_NUM
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] wb_rd_i,
    input  logic              wb_wreg_i,
    input  logic              mark_valid_i,
    input  logic [ADDR_W-1:0] mark_rd_i,
    input  logic              flush_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic              stallreq_o
);

    logic [NUM-1:0] pending_q;
    logic [NUM-1:0] pending_d;
    logic           hazard1;
    logic           hazard2;

    // Clear is applied before set so a new producer issued in the same cycle
    // its predecessor retires keeps the register pending.
    always_comb begin
        pending_d = pending_q;
        if (flush_i) begin
            pending_d = '0;
        end else begin
            if (wb_wreg_i == WRITE_ENABLE) begin
                pending_d[wb_rd_i] = 1'b0;
            end
            if (mark_valid_i && (mark_rd_i != '0)) begin
                pending_d[mark_rd_i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i == RST_ENABLE) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // A producer writing back this cycle is covered by the read bypass.
    always_comb begin
        hazard1 = re1_i && (raddr1_i != '0) && pending_q[raddr1_i]
                  && !(wb_wreg_i && (wb_rd_i == raddr1_i));
        hazard2 = re2_i && (raddr2_i != '0) && pending_q[raddr2_i]
                  && !(wb_wreg_i && (wb_rd_i == raddr2_i));
        stallreq_o = !rst_i && (hazard1 || hazard2);
    end

endmodule

// File: rtl/regfile_wb.sv
// regfile_wb
//   Architectural integer register file written from MEM/WB, with two
//   zero-latency read ports for ID (write-to-read bypass) and a load-use
//   scoreboard that raises stallreq.
//   Ports:
//     clk  clock
//     rst  synchronous reset, active-high
//     bus  regfile_wb_if.slave: wb_rd/wb_wdata/wb_wreg, re1/raddr1/rdata1,
//          re2/raddr2/rdata2, mark_valid/mark_rd, flush, stallreq
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W  = REG_BUS_W,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int REG_NUM = regfile_wb_pkg::REG_NUM
) (
    input  logic        clk,
    input  logic        rst,
    regfile_wb_if.slave bus
);

    logic [DATA_W-1:0] regs_q [REG_NUM];
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              stallreq;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else if ((bus.wb_wreg == WRITE_ENABLE) && (bus.wb_rd != '0)) begin
            regs_q[bus.wb_rd] <= bus.wb_wdata;
        end
    end

    // Index 0 never bypasses, so a discarded x0 write cannot leak through.
    always_comb begin
        rdata1 = '0;
        if (!rst && (bus.re1 == READ_ENABLE) && (bus.raddr1 != '0)) begin
            if (bus.wb_wreg && (bus.wb_rd == bus.raddr1)) begin
                rdata1 = bus.wb_wdata;
            end else begin
                rdata1 = regs_q[bus.raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (!rst && (bus.re2 == READ_ENABLE) && (bus.raddr2 != '0)) begin
            if (bus.wb_wreg && (bus.wb_rd == bus.raddr2)) begin
                rdata2 = bus.wb_wdata;
            end else begin
                rdata2 = regs_q[bus.raddr2];
            end
        end
    end

    regfile_wb_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM    (REG_NUM)
    ) u_scoreboard (
        .clk_i        (clk),
        .rst_i        (rst),
        .wb_rd_i      (bus.wb_rd),
        .wb_wreg_i    (bus.wb_wreg),
        .mark_valid_i (bus.mark_valid),
        .mark_rd_i    (bus.mark_rd),
        .flush_i      (bus.flush),
        .re1_i        (bus.re1),
        .raddr1_i     (bus.raddr1),
        .re2_i        (bus.re2),
        .raddr2_i     (bus.raddr2),
        .stallreq_o   (stallreq)
    );

    assign bus.rdata1   = rdata1;
    assign bus.rdata2   = rdata2;
    assign bus.stallreq = stallreq;

endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb
//   Directed bench for regfile_wb: reset, x0 protection, bypass, load-use
//   stall, set/clear collision, flush and mid-operation reset.
module tb_regfile_wb;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    regfile_wb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_wb #(.DATA_W(32), .ADDR_W(5), .REG_NUM(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_rd      = '0;
        bus.wb_wdata   = '0;
        bus.wb_wreg    = 1'b0;
        bus.re1        = 1'b0;
        bus.raddr1     = '0;
        bus.re2        = 1'b0;
        bus.raddr2     = '0;
        bus.mark_valid = 1'b0;
        bus.mark_rd    = '0;
        bus.flush      = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        bus.re1 = 1'b1; bus.raddr1 = 5'd5;
        tick(); tick();
        #2;
        total++;
        if (bus.rdata1 !== 32'h0) begin
            bad++; $display("FAIL reset_in_rst_rdata1 got=%h exp=%h", bus.rdata1, 32'h0);
        end
        rst = 1'b0;
        tick();
        idle();
        bus.re1 = 1'b1; bus.raddr1 = 5'd5;
        #2;
        total++;
        if (bus.rdata1 !== 32'h0) begin
            bad++; $display("FAIL reset_rdata1 got=%h exp=%h", bus.rdata1, 32'h0);
        end
        total++;
        if (bus.stallreq !== 1'b0) begin
            bad++; $display("FAIL reset_stallreq got=%b exp=%b", bus.stallreq, 1'b0);
        end
    endtask

    task automatic test_x0();
        tick(); idle();
        bus.wb_rd = 5'd0; bus.wb_wdata = 32'hDEADBEEF; bus.wb_wreg = 1'b1;
        bus.re1 = 1'b1; bus.raddr1 = 5'd0;
        #2;
        total++;
        if (bus.rdata1 !== 32'h0) begin
            bad++; $display("FAIL x0_same_cycle got=%h exp=%h", bus.rdata1, 32'h0);
        end
        tick(); idle();
        bus.re1 = 1'b1; bus.raddr1 = 5'd0;
        #2;
        total++;
        if (bus.rdata1 !== 32'h0) begin
            bad++; $display("FAIL x0_next_cycle got=%h exp=%h", bus.rdata1, 32'h0);
        end
    endtask

    task automatic test_bypass();
        tick(); idle();
        bus.wb_rd = 5'd7; bus.wb_wdata = 32'h12345678; bus.wb_wreg = 1'b1;
        bus.re2 = 1'b1; bus.raddr2 = 5'd7;
        bus.re1 = 1'b0; bus.raddr1 = 5'd7;
        #2;
        total++;
        if (bus.rdata2 !== 32'h12345678) begin
            bad++; $display("FAIL bypass_rdata2 got=%h exp=%h", bus.rdata2, 32'h12345678);
        end
        total++;
        if (bus.rdata1 !== 32'h0) begin
            bad++; $display("FAIL bypass_re1_off got=%h exp=%h", bus.rdata1, 32'h0);
        end
        tick(); idle();
        bus.re2 = 1'b1; bus.raddr2 = 5'd7;
        bus.re1 = 1'b1; bus.raddr1 = 5'd7;
        #2;
        total++;
        if (bus.rdata2 !== 32'h12345678) begin
            bad++; $display("FAIL stored_rdata2 got=%h exp=%h", bus.rdata2, 32'h12345678);
        end
        total++;
        if (bus.rdata1 !== 32'h12345678) begin
            bad++; $display("FAIL stored_rdata1 got=%h exp=%h", bus.rdata1, 32'h12345678);
        end
    endtask

    task automatic test_load_use();
        tick(); idle();
        bus.mark_valid = 1'b1; bus.mark_rd = 5'd3;
        for (int c = 0; c < 3; c++) begin
            tick(); idle();
            bus.re1 = 1'b1; bus.raddr1 = 5'd3;
            #2;
            total++;
            if (bus.stallreq !== 1'b1) begin
                bad++; $display("FAIL load_use_stall cyc=%0d got=%b exp=%b", c, bus.stallreq, 1'b1);
            end
        end
        tick(); idle();
        bus.re1 = 1'b1; bus.raddr1 = 5'd3;
        bus.wb_rd = 5'd3; bus.wb_wdata = 32'hA5A5A5A5; bus.wb_wreg = 1'b1;
        #2;
        total++;
        if (bus.stallreq !== 1'b0) begin
            bad++; $display("FAIL load_wb_stall got=%b exp=%b", bus.stallreq, 1'b0);
        end
        total++;
        if (bus.rdata1 !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL load_wb_rdata1 got=%h exp=%h", bus.rdata1, 32'hA5A5A5A5);
        end
        tick(); idle();
        bus.re1 = 1'b1; bus.raddr1 = 5'd3;
        #2;
        total++;
        if (bus.stallreq !== 1'b0) begin
            bad++; $display("FAIL load_cleared_stall got=%b exp=%b", bus.stallreq, 1'b0);
        end
        total++;
        if (bus.rdata1 !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL load_cleared_rdata1 got=%h exp=%h", bus.rdata1, 32'hA5A5A5A5);
        end
        // port 2 hazard, and gating by re2
        bus.mark_valid = 1'b1; bus.mark_rd = 5'd13;
        tick(); idle();
        bus.re2 = 1'b1; bus.raddr2 = 5'd13;
        #2;
        total++;
        if (bus.stallreq !== 1'b1) begin
            bad++; $display("FAIL port2_stall got=%b exp=%b", bus.stallreq, 1'b1);
        end
        bus.re2 = 1'b0;
        #1;
        total++;
        if (bus.stallreq !== 1'b0) begin
            bad++; $display("FAIL port2_re_off_stall got=%b exp=%b", bus.stallreq, 1'b0);
        end
        bus.wb_rd = 5'd13; bus.wb_wreg = 1'b1; bus.wb_wdata = 32'h0000_0013;
    endtask

    task automatic test_collision();
        tick(); idle();
        bus.mark_valid = 1'b1; bus.mark_rd = 5'd4;
        tick(); idle();
        bus.wb_rd = 5'd4; bus.wb_wdata = 32'h0000_0044; bus.wb_wreg = 1'b1;
        bus.mark_valid = 1'b1; bus.mark_rd = 5'd4;
        tick(); idle();
        bus.re1 = 1'b1; bus.raddr1 = 5'd4;
        #2;
        total++;
        if (bus.stallreq !== 1'b1) begin
            bad++; $display("FAIL collision_stall got=%b exp=%b", bus.stallreq, 1'b1);
        end
        total++;
        if (bus.rdata1 !== 32'h0000_0044) begin
            bad++; $display("FAIL collision_rdata1 got=%h exp=%h", bus.rdata1, 32'h0000_0044);
        end
        bus.wb_rd = 5'd4; bus.wb_wreg = 1'b1; bus.wb_wdata = 32'h0000_0045;
    endtask

    task automatic test_flush();
        tick(); idle();
        bus.mark_valid = 1'b1; bus.mark_rd = 5'd8;
        tick(); idle();
        bus.mark_valid = 1'b1; bus.mark_rd = 5'd9;
        bus.re1 = 1'b1; bus.raddr1 = 5'd8;
        #2;
        total++;
        if (bus.stallreq !== 1'b1) begin
            bad++; $display("FAIL flush_premark_stall got=%b exp=%b", bus.stallreq, 1'b1);
        end
        tick(); idle();
        bus.flush = 1'b1; bus.mark_valid = 1'b1; bus.mark_rd = 5'd10;
        tick(); idle();
        bus.re1 = 1'b1; bus.raddr1 = 5'd8;
        bus.re2 = 1'b1; bus.raddr2 = 5'd9;
        #2;
        total++;
        if (bus.stallreq !== 1'b0) begin
            bad++; $display("FAIL flush_8_9_stall got=%b exp=%b", bus.stallreq, 1'b0);
        end
        bus.raddr1 = 5'd10; bus.re2 = 1'b0;
        #1;
        total++;
        if (bus.stallreq !== 1'b0) begin
            bad++; $display("FAIL flush_10_stall got=%b exp=%b", bus.stallreq, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        tick(); idle();
        bus.wb_rd = 5'd12; bus.wb_wdata = 32'hCAFEF00D; bus.wb_wreg = 1'b1;
        tick(); idle();
        bus.mark_valid = 1'b1; bus.mark_rd = 5'd11;
        bus.re1 = 1'b1; bus.raddr1 = 5'd12;
        #2;
        total++;
        if (bus.rdata1 !== 32'hCAFEF00D) begin
            bad++; $display("FAIL mid_prewrite_rdata1 got=%h exp=%h", bus.rdata1, 32'hCAFEF00D);
        end
        tick(); idle();
        rst = 1'b1;
        bus.re1 = 1'b1; bus.raddr1 = 5'd12;
        bus.re2 = 1'b1; bus.raddr2 = 5'd11;
        bus.wb_rd = 5'd12; bus.wb_wdata = 32'h1111_1111; bus.wb_wreg = 1'b1;
        #2;
        total++;
        if (bus.rdata1 !== 32'h0) begin
            bad++; $display("FAIL mid_rst_rdata1 got=%h exp=%h", bus.rdata1, 32'h0);
        end
        total++;
        if (bus.stallreq !== 1'b0) begin
            bad++; $display("FAIL mid_rst_stall got=%b exp=%b", bus.stallreq, 1'b0);
        end
        tick(); idle();
        rst = 1'b0;
        bus.re1 = 1'b1; bus.raddr1 = 5'd12;
        bus.re2 = 1'b1; bus.raddr2 = 5'd11;
        #2;
        total++;
        if (bus.rdata1 !== 32'h0) begin
            bad++; $display("FAIL mid_after_rst_rdata1 got=%h exp=%h", bus.rdata1, 32'h0);
        end
        total++;
        if (bus.stallreq !== 1'b0) begin
            bad++; $display("FAIL mid_after_rst_stall got=%b exp=%b", bus.stallreq, 1'b0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();
        test_reset();
        test_x0();
        test_bypass();
        test_load_use();
        test_collision();
        test_flush();
        test_reset_mid();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Architectural integer register file; the write side is driven by the MEM/WB pipeline register outputs (wb_rd, wb_wdata, wb_wreg).
- Serves two combinational read ports to the ID stage, with same-cycle write-to-read bypass.
- Holds a per-register pending scoreboard: ID marks load destinations at issue, and writeback clears them.
- Raises a stall request to the stall controller when ID reads a register whose producer has not yet written back.

Parameters:
- DATA_W, 32, register width (`RegBus).
- ADDR_W, 5, register index width (`RegAddrBus).
- REG_NUM, 32, number of registers; index 0 is hardwired zero.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high (`RstEnable).
- wb_rd  in  ADDR_W  writeback destination index.
- wb_wdata  in  DATA_W  writeback data.
- wb_wreg  in  1  writeback enable (`WriteEnable).
- re1  in  1  read port 1 enable.
- raddr1  in  ADDR_W  read port 1 index.
- rdata1  out  DATA_W  read port 1 data.
- re2  in  1  read port 2 enable.
- raddr2  in  ADDR_W  read port 2 index.
- rdata2  out  DATA_W  read port 2 data.
- mark_valid  in  1  ID issues a long-latency (load) producer this cycle.
- mark_rd  in  ADDR_W  destination of the marked producer.
- flush  in  1  pipeline flush; clears all pending marks.
- stallreq  out  1  ID must stall; feeds the stall controller (`Stop).

Behaviour:
- Storage: REG_NUM x DATA_W array plus pending[REG_NUM-1:0]. All sequential state updates on posedge clk only.
- Reset (rst=1 at posedge): all registers become `ZeroWord and pending becomes 0. A writeback or mark in the same cycle is ignored.
- While rst=1, rdata1/rdata2 are combinationally `ZeroWord and stallreq=0.
- Write: at posedge, if wb_wreg=1 and wb_rd!=0, then reg[wb_rd]<=wb_wdata.
  - wb_rd=0 is discarded; reg[0] reads zero always.
- Read, combinational, zero latency. For port n:
  - ren=0 gives `ZeroWord.
  - raddrn=0 gives `ZeroWord.
  - If wb_wreg=1 and wb_rd=raddrn (nonzero), the output is wb_wdata (bypass).
  - Otherwise the output is reg[raddrn].
- Scoreboard update at posedge, in this priority order:
  1. rst: clear all.
  2. flush=1: clear all. A mark in the same cycle is dropped.
  3. Otherwise:
     - clear pending[wb_rd] if wb_wreg=1.
     - then set pending[mark_rd] if mark_valid=1 and mark_rd!=0.
     - If the same index is both cleared and set in one cycle, set wins (the new producer supersedes).
- Writeback with wb_wreg=1 to a non-pending register is legal (ALU results) and has no scoreboard effect beyond the clear.
- stallreq is combinational and equals 1 iff, for either port n: ren=1, raddrn!=0, pending[raddrn]=1, and NOT (wb_wreg=1 and wb_rd=raddrn).
  - A producer writing back in the same cycle is resolved by the bypass and does not stall.
- stallreq does not depend on mark_valid in the same cycle. A back-to-back load-use pair is caught on the following cycle, because ID holds the consumer while stalled.
- Reset mid-operation: pending marks are lost, which is intended; the whole pipeline is reset together.
- The block has no internal notion of the stall vector. The stall controller gates mark_valid, so it is asserted only for an instruction that actually leaves ID.

Decomposition:
- Shared defines header already carries `RstEnable, `ZeroWord, `WriteEnable, `WriteDisable, `ReadEnable, `RegBus, `RegAddrBus, `NOPRegAddr and `Stop.
- Add `RegNum (32) and `RegNumLog2 (5) there.
- One natural sub-module: regfile_scoreboard, holding pending[], set/clear/flush priority, and the stallreq compare.
- The data array and the bypass muxes stay in regfile_wb.

Test Plan:
1. Reset then read: rst=1 for 2 cycles, then re1=1, raddr1=5 → rdata1=0x00000000, stallreq=0.
2. x0 protection: write wb_rd=0, wb_wdata=0xDEADBEEF, wb_wreg=1; next cycle read raddr1=0 → 0x00000000.
3. Bypass: wb_rd=7, wb_wdata=0x12345678, wb_wreg=1, with re2=1, raddr2=7 in the same cycle → rdata2=0x12345678 combinationally; the value persists on the next cycle with wb_wreg=0.
4. Load-use stall:
   - mark_valid=1, mark_rd=3; next cycle re1=1, raddr1=3 → stallreq=1.
   - Hold 2 cycles, then wb_rd=3, wb_wreg=1, wb_wdata=0xA5A5A5A5 → stallreq=0 in that cycle and rdata1=0xA5A5A5A5.
   - Following cycle pending[3]=0.
5. Set/clear collision: pending[4]=1, then the same cycle has wb_rd=4, wb_wreg=1 and mark_valid=1, mark_rd=4 → next cycle read of 4 has stallreq=1.
6. Flush: mark regs 8 and 9, then flush=1 together with mark_rd=10 → next cycle reads of 8, 9 and 10 all have stallreq=0.
